// File: rtl/branch_resolve_predict_pkg.sv
// Shared encodings for the branch resolve / predict unit: next-PC select codes,
// jump and branch type codes, and the BHT counter reset value.
package branch_resolve_predict_pkg;

   typedef enum logic [1:0] {
      PcSrc4      = 2'd0,
      PcSrcImm    = 2'd1,
      PcSrcRegImm = 2'd2,
      PcSrcEx4    = 2'd3
   } pc_src_e;

   typedef enum logic [1:0] {
      JumpNone = 2'd0,
      JumpJal  = 2'd1,
      JumpJalr = 2'd2
   } jump_e;

   typedef enum logic [2:0] {
      BranchNone = 3'd0,
      BranchBeq  = 3'd1,
      BranchBne  = 3'd2,
      BranchBlt  = 3'd3,
      BranchBge  = 3'd4
   } branch_e;

   // Weakly not-taken.
   localparam logic [1:0] BhtResetVal = 2'b01;

endpackage

// File: rtl/branch_resolve_predict_sat_counter2.sv
// 2-bit up/down saturating counter with enable; one BHT entry.
module sat_counter2 #(
   parameter logic [1:0] ResetVal = 2'b01
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en_i,
   input  logic       up_i,
   output logic [1:0] cnt_o
);

   logic [1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         if (up_i) begin
            if (cnt_q != 2'b11) cnt_d = cnt_q + 2'd1;
         end else begin
            if (cnt_q != 2'b00) cnt_d = cnt_q - 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= ResetVal;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_resolve_predict.sv
// Resolves EX branches/jumps into a next-PC select and flush, trains a BHT of
// 2-bit counters read by ID, and counts resolved and mispredicted branches.
module branch_resolve_predict
   import branch_resolve_predict_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned BHT_ENTRIES = 16,
   parameter int unsigned IDX_LSB     = 2,
   parameter int unsigned PERF_W      = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [XLEN-1:0]   id_pc,
   output logic              id_pred_taken,
   input  logic              ex_valid,
   input  logic              ex_stall,
   input  logic [XLEN-1:0]   ex_pc,
   input  logic [1:0]        ex_jump,
   input  logic [2:0]        ex_branch,
   input  logic              ex_zero,
   input  logic              ex_neg,
   input  logic              ex_pred_taken,
   output logic [1:0]        pc_src,
   output logic              flush,
   output logic [PERF_W-1:0] perf_branches,
   output logic [PERF_W-1:0] perf_mispredicts
);

   localparam int unsigned IdxW = $clog2(BHT_ENTRIES);

   logic [IdxW-1:0]        id_idx;
   logic [IdxW-1:0]        ex_idx;
   logic [1:0]             bht_cnt [BHT_ENTRIES];
   logic [BHT_ENTRIES-1:0] bht_en;

   logic ex_go;
   logic is_jump;
   logic br_valid;
   logic br_taken;
   logic upd;

   logic [PERF_W-1:0] perf_branches_d, perf_branches_q;
   logic [PERF_W-1:0] perf_mispredicts_d, perf_mispredicts_q;

   assign id_idx = id_pc[IDX_LSB +: IdxW];
   assign ex_idx = ex_pc[IDX_LSB +: IdxW];

   // PC bits outside the index field are intentionally ignored.
   logic unused_pc;
   assign unused_pc = ^{id_pc, ex_pc};

   assign ex_go   = ex_valid && !ex_stall;
   assign is_jump = (ex_jump == JumpJal) || (ex_jump == JumpJalr);

   always_comb begin
      br_valid = 1'b1;
      br_taken = 1'b0;
      case (ex_branch)
         BranchBeq: br_taken = ex_zero;
         BranchBne: br_taken = !ex_zero;
         BranchBlt: br_taken = ex_neg;
         BranchBge: br_taken = !ex_neg;
         default:   br_valid = 1'b0;
      endcase
   end

   // Jumps take priority and never train the predictor.
   assign upd = ex_go && br_valid && !is_jump;

   always_comb begin
      pc_src = PcSrc4;
      flush  = 1'b0;
      if (ex_go) begin
         if (ex_jump == JumpJalr) begin
            pc_src = PcSrcRegImm;
            flush  = 1'b1;
         end else if (ex_jump == JumpJal) begin
            pc_src = PcSrcImm;
            flush  = 1'b1;
         end else if (br_valid && br_taken && !ex_pred_taken) begin
            pc_src = PcSrcImm;
            flush  = 1'b1;
         end else if (br_valid && !br_taken && ex_pred_taken) begin
            pc_src = PcSrcEx4;
            flush  = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < BHT_ENTRIES; g++) begin : g_bht
      assign bht_en[g] = upd && (ex_idx == IdxW'(g));

      sat_counter2 #(
         .ResetVal(BhtResetVal)
      ) u_cnt (
         .clk  (clk),
         .rst_n(rst_n),
         .en_i (bht_en[g]),
         .up_i (br_taken),
         .cnt_o(bht_cnt[g])
      );
   end

   // No bypass: a same-cycle update becomes visible after the edge.
   assign id_pred_taken = bht_cnt[id_idx][1];

   always_comb begin
      perf_branches_d    = perf_branches_q;
      perf_mispredicts_d = perf_mispredicts_q;
      if (upd) begin
         if (perf_branches_q != '1) perf_branches_d = perf_branches_q + PERF_W'(1);
         if ((br_taken != ex_pred_taken) && (perf_mispredicts_q != '1)) begin
            perf_mispredicts_d = perf_mispredicts_q + PERF_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_branches_q    <= '0;
         perf_mispredicts_q <= '0;
      end else begin
         perf_branches_q    <= perf_branches_d;
         perf_mispredicts_q <= perf_mispredicts_d;
      end
   end

   assign perf_branches    = perf_branches_q;
   assign perf_mispredicts = perf_mispredicts_q;

endmodule

// File: tb/tb_branch_resolve_predict.sv
// Bench for branch_resolve_predict: directed EX traffic against a table model,
// checked every cycle, plus literal expectations at key points.
module tb_branch_resolve_predict;
   import branch_resolve_predict_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] id_pc = '0;
   logic        ex_valid = 1'b0;
   logic        ex_stall = 1'b0;
   logic [31:0] ex_pc = '0;
   logic [1:0]  ex_jump = '0;
   logic [2:0]  ex_branch = '0;
   logic        ex_zero = 1'b0;
   logic        ex_neg = 1'b0;
   logic        ex_pred_taken = 1'b0;

   logic        id_pred_taken, flush, s_pred, s_flush;
   logic [1:0]  pc_src, s_pc_src;
   logic [31:0] perf_branches, perf_mispredicts;
   logic [3:0]  s_branches, s_mispredicts;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state: counter values 0..3, plain event counts.
   int     m_bht [16] = '{default: 1};
   longint m_br = 0, m_mis = 0, m_br_s = 0, m_mis_s = 0;

   always #5 clk = ~clk;

   branch_resolve_predict u_dut (
      .clk(clk), .rst_n(rst_n), .id_pc(id_pc), .id_pred_taken(id_pred_taken),
      .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_pc(ex_pc), .ex_jump(ex_jump),
      .ex_branch(ex_branch), .ex_zero(ex_zero), .ex_neg(ex_neg),
      .ex_pred_taken(ex_pred_taken), .pc_src(pc_src), .flush(flush),
      .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
   );

   branch_resolve_predict #(.PERF_W(4)) u_dut_s (
      .clk(clk), .rst_n(rst_n), .id_pc(id_pc), .id_pred_taken(s_pred),
      .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_pc(ex_pc), .ex_jump(ex_jump),
      .ex_branch(ex_branch), .ex_zero(ex_zero), .ex_neg(ex_neg),
      .ex_pred_taken(ex_pred_taken), .pc_src(s_pc_src), .flush(s_flush),
      .perf_branches(s_branches), .perf_mispredicts(s_mispredicts)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic bit is_br(input logic [2:0] b);
      return b >= 3'd1 && b <= 3'd4;
   endfunction

   function automatic bit actual(input logic [2:0] b, input logic z, input logic n);
      if (b == BranchBeq) return z;
      if (b == BranchBne) return !z;
      if (b == BranchBlt) return n;
      return !n;
   endfunction

   function automatic int idx(input logic [31:0] pc);
      return int'((pc >> 2) % 16);
   endfunction

   // Expected {pc_src, flush} from the priority rules.
   function automatic logic [2:0] exp_redirect();
      bit t;
      if (!ex_valid || ex_stall) return {2'd0, 1'b0};
      if (ex_jump == 2'd2) return {2'd2, 1'b1};
      if (ex_jump == 2'd1) return {2'd1, 1'b1};
      if (!is_br(ex_branch)) return {2'd0, 1'b0};
      t = actual(ex_branch, ex_zero, ex_neg);
      if (t && !ex_pred_taken) return {2'd1, 1'b1};
      if (!t && ex_pred_taken) return {2'd3, 1'b1};
      return {2'd0, 1'b0};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) m_bht[i] = 1;
         m_br = 0; m_mis = 0; m_br_s = 0; m_mis_s = 0;
      end else if (ex_valid && !ex_stall && is_br(ex_branch) &&
                   !(ex_jump == 2'd1 || ex_jump == 2'd2)) begin
         bit t;
         t = actual(ex_branch, ex_zero, ex_neg);
         if (t) m_bht[idx(ex_pc)] = (m_bht[idx(ex_pc)] == 3) ? 3 : m_bht[idx(ex_pc)] + 1;
         else   m_bht[idx(ex_pc)] = (m_bht[idx(ex_pc)] == 0) ? 0 : m_bht[idx(ex_pc)] - 1;
         if (m_br < 64'hFFFF_FFFF) m_br++;
         if (m_br_s < 15) m_br_s++;
         if (t != ex_pred_taken) begin
            if (m_mis < 64'hFFFF_FFFF) m_mis++;
            if (m_mis_s < 15) m_mis_s++;
         end
      end
   end

   always @(negedge clk) begin
      logic [2:0] r;
      r = exp_redirect();
      chk("pred", id_pred_taken, m_bht[idx(id_pc)] >= 2);
      chk("pc_src", pc_src, r[2:1]);
      chk("flush", flush, r[0]);
      chk("perf_branches", perf_branches, m_br);
      chk("perf_mispredicts", perf_mispredicts, m_mis);
      chk("s_pred", s_pred, m_bht[idx(id_pc)] >= 2);
      chk("s_pc_src", s_pc_src, r[2:1]);
      chk("s_perf_branches", s_branches, m_br_s);
      chk("s_perf_mispredicts", s_mispredicts, m_mis_s);
   end

   task automatic drive(input logic v, input logic s, input logic [31:0] pc,
                        input logic [1:0] j, input logic [2:0] b, input logic z,
                        input logic n, input logic p);
      ex_valid = v; ex_stall = s; ex_pc = pc; ex_jump = j; ex_branch = b;
      ex_zero = z; ex_neg = n; ex_pred_taken = p;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      drive(0, 0, 0, JumpNone, BranchNone, 0, 0, 0);
      repeat (3) tick();
      chk("lit_rst_branches", perf_branches, 0);
      chk("lit_rst_mispredicts", perf_mispredicts, 0);
      rst_n = 1'b1;
      for (int a = 0; a < 16; a++) begin
         id_pc = 32'(a * 4);
         #1;
         chk("lit_sweep_pred", id_pred_taken, 0);
         tick();
      end

      // Two taken beq at 0x40: mispredict, then correct.
      id_pc = 32'h40;
      drive(1, 0, 32'h40, JumpNone, BranchBeq, 1, 0, 0); #1;
      chk("lit_beq1_pc_src", pc_src, 2'd1);
      chk("lit_beq1_flush", flush, 1);
      chk("lit_beq1_pred_old", id_pred_taken, 0);
      tick();
      chk("lit_beq1_pred_new", id_pred_taken, 1);
      drive(1, 0, 32'h40, JumpNone, BranchBeq, 1, 0, 1); #1;
      chk("lit_beq2_pc_src", pc_src, 2'd0);
      chk("lit_beq2_flush", flush, 0);
      tick();
      chk("lit_beq2_branches", perf_branches, 2);
      chk("lit_beq2_mispredicts", perf_mispredicts, 1);

      // bne not taken but predicted taken: recover to ex_pc+4.
      drive(1, 0, 32'h40, JumpNone, BranchBne, 1, 0, 1); #1;
      chk("lit_bne_pc_src", pc_src, 2'd3);
      chk("lit_bne_flush", flush, 1);
      tick();
      chk("lit_bne_mispredicts", perf_mispredicts, 2);
      chk("lit_bne_pred", id_pred_taken, 1);

      // 0x80 aliases 0x40; same-cycle read still sees the old counter.
      drive(1, 0, 32'h80, JumpNone, BranchBne, 1, 0, 0); #1;
      chk("lit_alias_same_cycle", id_pred_taken, 1);
      tick();
      chk("lit_alias_after", id_pred_taken, 0);

      drive(1, 0, 32'h40, JumpJalr, BranchBeq, 1, 0, 0); #1;
      chk("lit_jalr_pc_src", pc_src, 2'd2);
      chk("lit_jalr_flush", flush, 1);
      tick();
      chk("lit_jalr_branches", perf_branches, 4);
      chk("lit_jalr_pred", id_pred_taken, 0);
      drive(1, 1, 32'h40, JumpJalr, BranchBeq, 1, 0, 0); #1;
      chk("lit_jalr_stall_pc_src", pc_src, 2'd0);
      chk("lit_jalr_stall_flush", flush, 0);
      tick();
      drive(1, 0, 32'h40, JumpJal, BranchBne, 0, 0, 0); #1;
      chk("lit_jal_pc_src", pc_src, 2'd1);
      tick();
      drive(1, 1, 32'h40, JumpNone, BranchBeq, 1, 0, 0); tick();
      drive(0, 0, 32'h40, JumpNone, BranchBeq, 1, 0, 0); tick();
      drive(1, 0, 32'h40, JumpNone, 3'd5, 1, 0, 1); #1;
      chk("lit_badcode_pc_src", pc_src, 2'd0);
      tick();
      chk("lit_nochange_branches", perf_branches, 4);
      chk("lit_nochange_pred", id_pred_taken, 0);

      // Saturate entry 1 low, then train it up; push counts past 15.
      id_pc = 32'h44;
      repeat (5) begin drive(1, 0, 32'h44, JumpNone, BranchBlt, 0, 0, 0); tick(); end
      chk("lit_sat_low_pred", id_pred_taken, 0);
      chk("lit_sat_low_branches", perf_branches, 9);
      repeat (2) begin drive(1, 0, 32'h44, JumpNone, BranchBlt, 0, 1, 0); tick(); end
      chk("lit_blt_up_pred", id_pred_taken, 1);
      chk("lit_blt_up_mispredicts", perf_mispredicts, 4);
      repeat (3) begin drive(1, 0, 32'h44, JumpNone, BranchBge, 0, 0, 1); tick(); end
      id_pc = 32'h48;
      repeat (3) begin drive(1, 0, 32'h48, JumpNone, BranchBeq, 1, 0, 1); tick(); end
      chk("lit_sat_pred_48", id_pred_taken, 1);
      chk("lit_sat_big_branches", perf_branches, 17);
      chk("lit_sat_small_branches", s_branches, 4'hF);
      chk("lit_sat_small_mispredicts", s_mispredicts, 4);

      // Async reset with an update pending.
      id_pc = 32'h44;
      drive(1, 0, 32'h44, JumpNone, BranchBeq, 0, 0, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("lit_midrst_pred", id_pred_taken, 0);
      chk("lit_midrst_branches", perf_branches, 0);
      tick(); tick();
      drive(0, 0, 0, JumpNone, BranchNone, 0, 0, 0);
      rst_n = 1'b1;
      for (int a = 0; a < 16; a++) begin
         id_pc = 32'(a * 4);
         #1;
         chk("lit_sweep2_pred", id_pred_taken, 0);
         tick();
      end
      id_pc = 32'h44;
      drive(1, 0, 32'h44, JumpNone, BranchBge, 0, 0, 0); tick();
      drive(0, 0, 0, JumpNone, BranchNone, 0, 0, 0); #1;
      chk("lit_post_rst_pred", id_pred_taken, 1);
      chk("lit_post_rst_branches", perf_branches, 1);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
